// File: rtl/commit_fifo.sv
// commit_fifo: dual-push, single-pop buffer of retired-instruction records feeding the trace fsm.
// Oldest records win on overflow; overflow_o stays set until reset or flush.
package commit_fifo_pkg;
    typedef struct packed {
        logic [31:0] iaddr;
        logic [31:0] tval;
        logic [4:0]  cause;
        logic [1:0]  priv;
        logic [2:0]  itype;
    } fifo_entry_s;
endpackage

module commit_fifo
    import commit_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        push_i,
    input  fifo_entry_s [1:0] entry_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output fifo_entry_s       entry_o,
    output logic              valid_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, free;
    logic             ovf_q, ovf_d, pop, drop;
    logic [1:0]       req, acc;
    fifo_entry_s      first;
    fifo_entry_s      mem_q [DEPTH];

    always_comb begin
        pop   = valid_o & ready_i;
        free  = CNT_W'(DEPTH) - cnt_q + CNT_W'(pop);
        req   = {1'b0, push_i[0]} + {1'b0, push_i[1]};
        drop  = CNT_W'(req) > free;
        // free < req <= 2 here, so the low two bits hold the whole value
        acc   = drop ? free[1:0] : req;
        first = push_i[0] ? entry_i[0] : entry_i[1];
        wr_d  = flush_i ? '0 : wr_q + PTR_W'(acc);
        rd_d  = flush_i ? '0 : rd_q + PTR_W'(pop);
        cnt_d = flush_i ? '0 : cnt_q + CNT_W'(acc) - CNT_W'(pop);
        ovf_d = flush_i ? 1'b0 : ovf_q | drop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i) begin
            if (acc != 2'd0) mem_q[wr_q] <= first;
            if (acc == 2'd2) mem_q[wr_q + PTR_W'(1)] <= entry_i[1];
        end
    end

    assign count_o    = cnt_q;
    assign empty_o    = cnt_q == '0;
    assign full_o     = cnt_q == CNT_W'(DEPTH);
    assign valid_o    = !empty_o;
    assign overflow_o = ovf_q;
    assign entry_o    = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: tb/tb_commit_fifo.sv
// tb_commit_fifo: directed stimulus with a queue scoreboard for commit_fifo.
module tb_commit_fifo;
    import commit_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [1:0]        push_i;
    fifo_entry_s [1:0] entry_i;
    logic              flush_i;
    logic              ready_i;
    fifo_entry_s       entry_o;
    logic              valid_o, empty_o, full_o, overflow_o;
    logic [CNT_W-1:0]  count_o;

    int checks = 0;
    int errors = 0;
    fifo_entry_s q[$];
    logic movf = 1'b0;
    int next_id = 1;
    fifo_entry_s z = '0;

    commit_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_i), .entry_i(entry_i),
        .flush_i(flush_i), .ready_i(ready_i), .entry_o(entry_o), .valid_o(valid_o),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic fifo_entry_s rec();
        fifo_entry_s r;
        r.iaddr = 32'h8000_0000 + 32'(next_id) * 4;
        r.tval  = $urandom;
        r.cause = 5'(next_id);
        r.priv  = 2'(next_id);
        r.itype = 3'(next_id);
        next_id++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 128'(count_o), 128'(q.size()));
        chk("empty", 128'(empty_o), 128'(q.size() == 0));
        chk("full", 128'(full_o), 128'(q.size() == DEPTH));
        chk("valid", 128'(valid_o), 128'(q.size() != 0));
        chk("overflow", 128'(overflow_o), 128'(movf));
        chk("entry", 128'(entry_o), q.size() != 0 ? 128'(q[0]) : 128'(0));
    endtask

    // Checks the current outputs, drives one cycle of inputs and advances the model.
    task automatic step(input logic [1:0] p, input fifo_entry_s e0, input fifo_entry_s e1,
                        input logic rdy, input logic fl);
        check_outputs();
        push_i = p; entry_i[0] = e0; entry_i[1] = e1; ready_i = rdy; flush_i = fl;
        if (fl) begin
            q.delete();
            movf = 1'b0;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (p[0]) begin if (q.size() < DEPTH) q.push_back(e0); else movf = 1'b1; end
            if (p[1]) begin if (q.size() < DEPTH) q.push_back(e1); else movf = 1'b1; end
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(2'b00, z, z, rdy, 1'b0);
    endtask

    initial begin
        fifo_entry_s a, b;
        rst_ni = 1'b0; push_i = 2'b11; entry_i[0] = rec(); entry_i[1] = rec();
        flush_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_entry", 128'(entry_o), 128'(0));
        chk("rst_overflow", 128'(overflow_o), 128'(0));
        chk("rst_empty", 128'(empty_o), 128'(1));
        rst_ni = 1'b1; push_i = 2'b00;
        idle(1'b1, 2);

        a = rec(); b = rec();
        step(2'b11, a, b, 1'b1, 1'b0);
        chk("dual_head_a", 128'(entry_o), 128'(a));
        idle(1'b1, 3);

        a = rec(); b = rec();
        step(2'b10, z, a, 1'b0, 1'b0);
        step(2'b01, b, z, 1'b0, 1'b0);
        chk("compact_count", 128'(count_o), 128'(2));
        chk("compact_head", 128'(entry_o), 128'(a));
        idle(1'b1, 3);

        for (int i = 0; i < DEPTH / 2; i++) step(2'b11, rec(), rec(), 1'b0, 1'b0);
        step(2'b11, rec(), rec(), 1'b0, 1'b0);
        chk("full_drop_ovf", 128'(overflow_o), 128'(1));
        chk("full_drop_count", 128'(count_o), 128'(DEPTH));
        step(2'b11, rec(), rec(), 1'b1, 1'b0);
        chk("full_pop_count", 128'(count_o), 128'(DEPTH));
        idle(1'b1, DEPTH + 2);
        step(2'b00, z, z, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            step(2'b01, rec(), z, 1'b1, 1'b0);
            chk("wrap_count_le1", 128'(count_o <= 1), 128'(1));
        end
        idle(1'b1, 2);
        chk("wrap_no_ovf", 128'(overflow_o), 128'(0));

        for (int i = 0; i < DEPTH / 2; i++) step(2'b11, rec(), rec(), 1'b0, 1'b0);
        step(2'b11, rec(), rec(), 1'b0, 1'b0);
        idle(1'b1, DEPTH - 5);
        chk("pre_flush_count", 128'(count_o), 128'(5));
        chk("pre_flush_ovf", 128'(overflow_o), 128'(1));
        step(2'b11, rec(), rec(), 1'b1, 1'b1);
        chk("flush_count", 128'(count_o), 128'(0));
        chk("flush_empty", 128'(empty_o), 128'(1));
        chk("flush_ovf", 128'(overflow_o), 128'(0));
        idle(1'b1, 2);

        for (int i = 0; i < 3; i++) step(2'b11, rec(), rec(), 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1 chk("async_rst_count", 128'(count_o), 128'(0));
        chk("async_rst_valid", 128'(valid_o), 128'(0));
        chk("async_rst_entry", 128'(entry_o), 128'(0));
        push_i = 2'b00;
        q.delete(); movf = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        a = rec();
        step(2'b01, a, z, 1'b0, 1'b0);
        chk("post_rst_head", 128'(entry_o), 128'(a));
        idle(1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
